pe_feeder: RTL and testbench

Transmit-side front end for one `pe_simd` lane. It takes instructions and complex data words from upstream valid/ready streams and drives the PE's `inst_in_v`/`inst_in` and `din_v`/`din_pe` inputs. The PE counts `din_v` cycles to fill its shift-register array, then reads it back. The feeder therefore buffers a whole burst and emits it with no gaps, followed by the read-phase hold window. It sits between the array-level distributor and each PE.

---
 rtl/pe_feeder.sv | 153 +++++++++++++++
 tb/tb_pe_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Transmit-side front end for one pe_simd lane: loads a program, buffers a data
// burst, then streams it gap-free followed by the PE readback hold window.
`timescale 1ns/1ps
module pe_feeder #(
   parameter int WORD_W   = 32,
   parameter int INST_W   = 64,
   parameter int BURST    = 32,
   parameter int INST_NUM = 16,
   parameter int GAP      = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_start,
   input  logic              flush,
   input  logic              s_inst_valid,
   output logic              s_inst_ready,
   input  logic [INST_W-1:0] s_inst_data,
   input  logic              s_data_valid,
   output logic              s_data_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              inst_in_v,
   output logic [INST_W-1:0] inst_in,
   output logic              din_v,
   output logic [WORD_W-1:0] din_pe,
   output logic              busy,
   output logic              burst_done,
   output logic [15:0]       burst_cnt
);

   localparam int IDX_W = $clog2(BURST);
   localparam int ICW   = $clog2(INST_NUM) + 1;
   localparam int GCW   = $clog2(GAP) + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_INST, ST_FILL, ST_SEND, ST_HOLD, ST_GAP} state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
   logic [IDX_W-1:0]  cnt_reg, cnt_next;
   logic [ICW-1:0]    inst_cnt_reg, inst_cnt_next;
   logic [GCW-1:0]    gap_cnt_reg, gap_cnt_next;
   logic [WORD_W-1:0] buf_mem [BURST];

   logic              inst_hs, data_hs;
   logic              inst_v_next, done_next;
   logic              inst_v_reg, din_v_reg, burst_done_reg;
   logic [INST_W-1:0] inst_in_reg;
   logic [WORD_W-1:0] din_pe_reg;
   logic [15:0]       burst_cnt_reg;

   // Ready/busy decode only the state register, never the incoming valid.
   assign s_inst_ready = (state_reg == ST_INST);
   assign s_data_ready = (state_reg == ST_FILL);
   assign busy         = (state_reg != ST_IDLE);
   assign inst_hs      = s_inst_valid & s_inst_ready;
   assign data_hs      = s_data_valid & s_data_ready;

   always_comb begin
      state_next    = state_reg;
      wr_idx_next   = wr_idx_reg;
      cnt_next      = cnt_reg;
      inst_cnt_next = inst_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      case (state_reg)
         ST_IDLE: if (prog_start) state_next = ST_INST;
         ST_INST: if (inst_hs) begin
            if (inst_cnt_reg == ICW'(INST_NUM - 1)) begin
               state_next    = ST_FILL;
               inst_cnt_next = '0;
            end else begin
               inst_cnt_next = inst_cnt_reg + 1'b1;
            end
         end
         ST_FILL: if (data_hs) begin
            wr_idx_next = wr_idx_reg + 1'b1;
            if (wr_idx_reg == IDX_W'(BURST - 1)) begin
               state_next = ST_SEND;
               cnt_next   = '0;
            end
         end
         ST_SEND: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == IDX_W'(BURST - 1)) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == IDX_W'(BURST - 1)) begin
               state_next   = ST_GAP;
               gap_cnt_next = '0;
            end
         end
         ST_GAP: begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
            if (gap_cnt_reg == GCW'(GAP - 1)) begin
               state_next   = ST_FILL;
               gap_cnt_next = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (flush) begin
         state_next    = ST_IDLE;
         wr_idx_next   = '0;
         cnt_next      = '0;
         inst_cnt_next = '0;
         gap_cnt_next  = '0;
      end
   end

   assign inst_v_next = inst_hs & ~flush;
   // PE outputs are computed from the next state so they line up with it.
   assign done_next   = (state_next == ST_HOLD) && (cnt_next == IDX_W'(BURST - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         wr_idx_reg     <= '0;
         cnt_reg        <= '0;
         inst_cnt_reg   <= '0;
         gap_cnt_reg    <= '0;
         inst_v_reg     <= 1'b0;
         inst_in_reg    <= '0;
         din_v_reg      <= 1'b0;
         din_pe_reg     <= '0;
         burst_done_reg <= 1'b0;
         burst_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         wr_idx_reg     <= wr_idx_next;
         cnt_reg        <= cnt_next;
         inst_cnt_reg   <= inst_cnt_next;
         gap_cnt_reg    <= gap_cnt_next;
         inst_v_reg     <= inst_v_next;
         inst_in_reg    <= inst_v_next ? s_inst_data : '0;
         din_v_reg      <= (state_next == ST_SEND) || (state_next == ST_HOLD);
         din_pe_reg     <= (state_next == ST_SEND) ? buf_mem[cnt_next] : '0;
         burst_done_reg <= done_next;
         if (done_next) burst_cnt_reg <= burst_cnt_reg + 16'd1;
      end
   end

   // Buffer contents survive reset; only the indices are cleared.
   always_ff @(posedge clk) begin
      if (data_hs) buf_mem[wr_idx_reg] <= s_data;
   end

   assign inst_in_v  = inst_v_reg;
   assign inst_in    = inst_in_reg;
   assign din_v      = din_v_reg;
   assign din_pe     = din_pe_reg;
   assign burst_done = burst_done_reg;
   assign burst_cnt  = burst_cnt_reg;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: program load, bursts, gaps, flush, prog_start
// during FILL and asynchronous reset during HOLD.
`timescale 1ns/1ps
module tb_pe_feeder;

   localparam int WORD_W   = 32;
   localparam int INST_W   = 64;
   localparam int BURST    = 32;
   localparam int INST_NUM = 16;
   localparam int GAP      = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              prog_start, flush;
   logic              s_inst_valid, s_inst_ready;
   logic [INST_W-1:0] s_inst_data;
   logic              s_data_valid, s_data_ready;
   logic [WORD_W-1:0] s_data;
   logic              inst_in_v;
   logic [INST_W-1:0] inst_in;
   logic              din_v;
   logic [WORD_W-1:0] din_pe;
   logic              busy, burst_done;
   logic [15:0]       burst_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   pe_feeder #(
      .WORD_W(WORD_W), .INST_W(INST_W), .BURST(BURST), .INST_NUM(INST_NUM), .GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst), .prog_start(prog_start), .flush(flush),
      .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready), .s_inst_data(s_inst_data),
      .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data(s_data),
      .inst_in_v(inst_in_v), .inst_in(inst_in), .din_v(din_v), .din_pe(din_pe),
      .busy(busy), .burst_done(burst_done), .burst_cnt(burst_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog(input bit gappy);
      int acc = 0;
      int pulses = 0;
      int c = 0;
      logic hs;
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      check_eq("prog_busy", 64'(busy), 64'd1);
      check_eq("prog_inst_ready", 64'(s_inst_ready), 64'd1);
      while (acc < INST_NUM && c < 200) begin
         s_inst_valid = gappy ? (c % 3 != 2) : 1'b1;
         s_inst_data  = 64'(acc + 1);
         hs = s_inst_valid && s_inst_ready;
         tick();
         c++;
         check_eq("inst_v_latency", 64'(inst_in_v), 64'(hs));
         if (inst_in_v) pulses++;
         if (hs) begin
            check_eq("inst_data", inst_in, 64'(acc + 1));
            acc++;
         end
      end
      s_inst_valid = 1'b0;
      check_eq("fill_ready_after_prog", 64'(s_data_ready), 64'd1);
      check_eq("inst_ready_after_prog", 64'(s_inst_ready), 64'd0);
      tick();
      check_eq("inst_v_after_prog", 64'(inst_in_v), 64'd0);
      check_eq("inst_pulse_count", 64'(pulses), 64'(INST_NUM));
   endtask

   task automatic fill_words(input logic [31:0] base, input int start, input int n,
                             input bit gappy, input bit hold_valid, output int cycles);
      int acc = start;
      logic hs;
      cycles = 0;
      while (acc < start + n && cycles < 500) begin
         s_data_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_data       = base + 32'(acc);
         hs = s_data_valid && s_data_ready;
         tick();
         cycles++;
         if (hs) acc++;
      end
      s_data_valid = hold_valid;
      check_eq("fill_accepted", 64'(acc), 64'(start + n));
   endtask

   task automatic check_send_hold(input logic [31:0] base, input int exp_cnt);
      for (int k = 0; k < 2 * BURST; k++) begin
         check_eq("din_v_run", 64'(din_v), 64'd1);
         check_eq("din_pe", 64'(din_pe), (k < BURST) ? 64'(base) + 64'(k) : 64'd0);
         check_eq("burst_done", 64'(burst_done), 64'(k == 2 * BURST - 1));
         check_eq("ready_low_send", 64'(s_data_ready), 64'd0);
         tick();
      end
      check_eq("din_v_after_hold", 64'(din_v), 64'd0);
      check_eq("burst_done_after", 64'(burst_done), 64'd0);
      check_eq("burst_cnt", 64'(burst_cnt), 64'(exp_cnt));
   endtask

   task automatic gap_wait();
      int g = 0;
      while (!s_data_ready && g < 100) begin
         check_eq("gap_din_v", 64'(din_v), 64'd0);
         tick();
         g++;
      end
      check_eq("gap_len", 64'(g), 64'(GAP));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; prog_start = 1'b0; flush = 1'b0;
      s_inst_valid = 1'b0; s_inst_data = '0; s_data_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      tick(); tick();
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_din_v", 64'(din_v), 64'd0);
      check_eq("rst_inst_v", 64'(inst_in_v), 64'd0);
      check_eq("rst_burst_cnt", 64'(burst_cnt), 64'd0);
      check_eq("rst_inst_ready", 64'(s_inst_ready), 64'd0);
      check_eq("rst_data_ready", 64'(s_data_ready), 64'd0);

      // program load with stalls, then a burst with random valid gaps
      load_prog(1'b1);
      fill_words(32'hA000_0000, 0, BURST, 1'b1, 1'b0, cyc);
      check_send_hold(32'hA000_0000, 1);

      // back-to-back bursts with the source always valid
      gap_wait();
      fill_words(32'hC000_0000, 0, BURST, 1'b0, 1'b1, cyc);
      check_eq("fill_cycles", 64'(cyc), 64'(BURST));
      check_send_hold(32'hC000_0000, 2);
      gap_wait();
      fill_words(32'hD000_0000, 0, BURST, 1'b0, 1'b0, cyc);
      check_send_hold(32'hD000_0000, 3);

      // flush on the 10th SEND cycle
      gap_wait();
      fill_words(32'hE000_0000, 0, BURST, 1'b0, 1'b0, cyc);
      repeat (9) tick();
      check_eq("send10_data", 64'(din_pe), 64'h0000_0000_E000_0009);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("flush_din_v", 64'(din_v), 64'd0);
      check_eq("flush_busy", 64'(busy), 64'd0);
      check_eq("flush_burst_cnt", 64'(burst_cnt), 64'd3);
      check_eq("flush_data_ready", 64'(s_data_ready), 64'd0);

      // flush beats prog_start in the same cycle
      prog_start = 1'b1; flush = 1'b1;
      tick();
      prog_start = 1'b0; flush = 1'b0;
      check_eq("flush_wins_busy", 64'(busy), 64'd0);
      check_eq("flush_wins_inst_ready", 64'(s_inst_ready), 64'd0);

      // prog_start during FILL must not disturb the burst
      load_prog(1'b0);
      fill_words(32'hF000_0000, 0, 10, 1'b0, 1'b0, cyc);
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      check_eq("midfill_busy", 64'(busy), 64'd1);
      check_eq("midfill_data_ready", 64'(s_data_ready), 64'd1);
      check_eq("midfill_inst_ready", 64'(s_inst_ready), 64'd0);
      check_eq("midfill_burst_cnt", 64'(burst_cnt), 64'd3);
      fill_words(32'hF000_0000, 10, BURST - 10, 1'b0, 1'b0, cyc);
      check_send_hold(32'hF000_0000, 4);

      // asynchronous reset during HOLD
      gap_wait();
      fill_words(32'h9000_0000, 0, BURST, 1'b0, 1'b0, cyc);
      repeat (BURST + 5) tick();
      check_eq("hold_din_v", 64'(din_v), 64'd1);
      check_eq("hold_din_pe", 64'(din_pe), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_din_v", 64'(din_v), 64'd0);
      check_eq("arst_burst_cnt", 64'(burst_cnt), 64'd0);
      check_eq("arst_data_ready", 64'(s_data_ready), 64'd0);
      check_eq("arst_inst_ready", 64'(s_inst_ready), 64'd0);
      check_eq("arst_burst_done", 64'(burst_done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // full rerun after reset
      load_prog(1'b1);
      fill_words(32'hA000_0000, 0, BURST, 1'b1, 1'b0, cyc);
      check_send_hold(32'hA000_0000, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
